// File: rtl/snn_readout_pkg.sv
// -----------------------------------------------------------------------------
// snn_readout_pkg
// Shared definitions for the SNN winner-take-all readout:
//   - state_e     : readout FSM state encoding (IDLE/COUNT/DECIDE/HOLD)
//   - idx_width() : class-index width helper, never narrower than one bit
//   - IDX_WIDTH   : index width for the default three-class configuration
//   - count_t / window_t : default-width counter and window-length types
// No ports (package).
// -----------------------------------------------------------------------------
package snn_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_DECIDE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_NUM_CLASSES  = 3;
  localparam int DEFAULT_COUNT_WIDTH  = 8;
  localparam int DEFAULT_WINDOW_WIDTH = 16;
  localparam int IDX_WIDTH            = idx_width(DEFAULT_NUM_CLASSES);

  typedef logic [DEFAULT_COUNT_WIDTH-1:0]  count_t;
  typedef logic [DEFAULT_WINDOW_WIDTH-1:0] window_t;

endpackage

// File: rtl/snn_sat_counter.sv
// -----------------------------------------------------------------------------
// snn_sat_counter
// Saturating up-counter, one per output class. Holds at all-ones.
// Ports:
//   clk   in   clock
//   rst_n in   asynchronous active-low reset
//   clr   in   synchronous clear (wins over inc)
//   inc   in   count one event this cycle
//   q     out  current count
// -----------------------------------------------------------------------------
module snn_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/snn_spike_window_classifier.sv
// -----------------------------------------------------------------------------
// snn_spike_window_classifier
// Windowed winner-take-all readout for the SNN output layer. Counts spikes per
// class over window_len cycles, then scans the counts one class per cycle to
// find the winner (ties go to the lowest index) and holds the result on a
// valid/ready handshake.
//
// Optional feature macro: SNN_READOUT_MARGIN_EN
//   defined   : runner-up tracked during the scan; low_conf flags a weak win
//   undefined : low_conf tied to 0, MARGIN unused
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   spike_in       per-class spike pulses (counted only in COUNT)
//   start          begin a window (accepted only in IDLE)
//   window_len     window length, latched on accepted start
//   abort          return to IDLE next cycle, drops result_valid
//   busy           registered "state != IDLE"
//   result_valid   result held in HOLD
//   result_ready   consumer accepts the result
//   winner         winning class index
//   winner_count   count of the winning class
//   no_spike       all counts were zero
//   low_conf       margin flag (0 without the macro)
//   counts         per-class counts, class i at [i*COUNT_WIDTH +: COUNT_WIDTH]
//   state_dbg      current FSM state (see snn_readout_pkg::state_e)
//
// Handshake: result_valid stays high and all result outputs stay stable until
// the edge where result_valid && result_ready; that edge returns to IDLE.
// abort has priority over the handshake, which has priority over start.
// -----------------------------------------------------------------------------
module snn_spike_window_classifier
  import snn_readout_pkg::*;
#(
  parameter int NUM_CLASSES  = 3,
  parameter int COUNT_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 16,
  parameter int MARGIN       = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CLASSES-1:0]             spike_in,
  input  logic                               start,
  input  logic [WINDOW_WIDTH-1:0]            window_len,
  input  logic                               abort,
  output logic                               busy,
  output logic                               result_valid,
  input  logic                               result_ready,
  output logic [$clog2(NUM_CLASSES)-1:0]     winner,
  output logic [COUNT_WIDTH-1:0]             winner_count,
  output logic                               no_spike,
  output logic                               low_conf,
  output logic [NUM_CLASSES*COUNT_WIDTH-1:0] counts,
  output logic [1:0]                         state_dbg
);

  localparam int IDX_W = idx_width(NUM_CLASSES);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_COUNT  = ST_COUNT;
  localparam logic [1:0] S_DECIDE = ST_DECIDE;
  localparam logic [1:0] S_HOLD   = ST_HOLD;

  logic [1:0]              state, state_next;
  logic [WINDOW_WIDTH-1:0] win_cnt;
  logic [IDX_W-1:0]        scan_idx;
  logic [COUNT_WIDTH-1:0]  cnt [NUM_CLASSES];
  logic [COUNT_WIDTH-1:0]  best_cnt;
  logic [IDX_W-1:0]        best_idx;
  logic [COUNT_WIDTH-1:0]  cur_cnt;
  logic                    take;
  logic [COUNT_WIDTH-1:0]  new_best;
  logic [IDX_W-1:0]        new_idx;
  logic                    start_acc;
  logic                    scan_last;

  assign state_dbg = state;
  assign start_acc = (state == S_IDLE) && start && !abort;
  assign scan_last = (scan_idx == IDX_W'(NUM_CLASSES - 1));

  // Per-class counters; cleared on an accepted start, count only in COUNT.
  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_class
    snn_sat_counter #(.WIDTH(COUNT_WIDTH)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_acc),
      .inc   ((state == S_COUNT) && spike_in[i]),
      .q     (cnt[i])
    );
    assign counts[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt[i];
  end

  // Scan step: index 0 seeds the best; later indices replace it only when
  // strictly greater, so ties keep the lower index.
  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (scan_idx == IDX_W'(i)) cur_cnt = cnt[i];
    end
    take     = (scan_idx == '0) || (cur_cnt > best_cnt);
    new_best = take ? cur_cnt : best_cnt;
    new_idx  = take ? scan_idx : best_idx;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_next = (window_len == '0) ? S_DECIDE : S_COUNT;
        S_COUNT:  if (win_cnt == WINDOW_WIDTH'(1)) state_next = S_DECIDE;
        S_DECIDE: if (scan_last) state_next = S_HOLD;
        S_HOLD:   if (result_ready) state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      win_cnt      <= '0;
      scan_idx     <= '0;
      best_cnt     <= '0;
      best_idx     <= '0;
      result_valid <= 1'b0;
      winner       <= '0;
      winner_count <= '0;
      no_spike     <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
      case (state)
        S_IDLE: begin
          scan_idx <= '0;
          if (start_acc) win_cnt <= window_len;
        end
        S_COUNT: begin
          scan_idx <= '0;
          win_cnt  <= win_cnt - WINDOW_WIDTH'(1);
        end
        S_DECIDE: begin
          best_cnt <= new_best;
          best_idx <= new_idx;
          scan_idx <= scan_idx + IDX_W'(1);
          if (scan_last && !abort) begin
            result_valid <= 1'b1;
            winner       <= new_idx;
            winner_count <= new_best;
            no_spike     <= (new_best == '0);
          end
        end
        default: ;
      endcase
      if (abort || ((state == S_HOLD) && result_valid && result_ready)) begin
        result_valid <= 1'b0;
      end
    end
  end

`ifdef SNN_READOUT_MARGIN_EN
  // Runner-up: a value equal to the current best (a tie) becomes runner-up,
  // so tied winners report zero margin.
  logic [COUNT_WIDTH-1:0] run_cnt;
  logic [COUNT_WIDTH-1:0] new_run;
  logic                   low_conf_q;

  always_comb begin
    if (scan_idx == '0)           new_run = '0;
    else if (cur_cnt > best_cnt)  new_run = best_cnt;
    else if (cur_cnt > run_cnt)   new_run = cur_cnt;
    else                          new_run = run_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt    <= '0;
      low_conf_q <= 1'b0;
    end else if (state == S_DECIDE) begin
      run_cnt <= new_run;
      if (scan_last && !abort) begin
        low_conf_q <= (new_best == '0) ||
                      ((new_best - new_run) < COUNT_WIDTH'(MARGIN));
      end
    end
  end

  assign low_conf = low_conf_q;
`else
  assign low_conf = 1'b0;
`endif

endmodule
